seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display; sits between the value producer and the `segment`/`anode` pins in `design_top`.
- Sequences digits 0..3 with a guard interval between digits and PWM brightness within each digit slot, and applies leading-zero blanking.
- Double-buffers display data: new values are accepted via valid/ready and applied only at frame boundaries, so there is no tearing.

## Interface
Parameters:
- SUB_CYC, 3125, clocks per PWM sub-slot; 16 sub-slots per digit, so 1 kHz digit rate at 50 MHz.
- GUARD_CYC, 16, clocks with all anodes off at the start of each digit slot (≥1).

Ports:
- clk  in  1  system clock, 50 MHz.
- rstN  in  1  reset, asynchronous, active-low.
- refresh_clk_en  in  1  scan enable; 0 blanks the display and idles the FSM.
- wr_valid  in  1  producer offers wr_data/wr_dp.
- wr_ready  out  1  controller can accept a write.
- wr_data  in  16  four hex nibbles; [3:0] is digit 0 (rightmost).
- wr_dp  in  4  decimal point per digit; 1 = lit.
- brightness  in  4  on-time = (brightness+1)/16 of the drive window.
- blank_lz  in  1  enables leading-zero blanking.
- segment  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- anode  out  4  anode[i] low = digit i on.
- digit_idx  out  2  digit owning the current slot.
- frame_done  out  1  one-cycle pulse on the last cycle of the digit-3 slot.

## Operation
- FSM states: IDLE, GUARD, DRIVE, OFF.
- IDLE:
  - Entered on reset, or when refresh_clk_en=0 in any state.
  - Leaves to GUARD, digit 0, when refresh_clk_en=1. This entry is a frame start.
- GUARD:
  - Lasts GUARD_CYC cycles with anode=4'hF.
  - segment/dp are loaded with the slot digit's code on the entry cycle.
  - brightness is sampled on the entry cycle and held for the slot.
- DRIVE:
  - Lasts (b+1)*SUB_CYC cycles.
  - anode has bit digit_idx low, unless the digit is blanked.
- OFF:
  - Lasts (15-b)*SUB_CYC cycles with anode=4'hF.
  - Skipped when b=15.
- Slot end: digit_idx increments mod 4 and the FSM returns to GUARD. The wrap from 3 to 0 is a frame start.
- Slot length is always GUARD_CYC+16*SUB_CYC, independent of brightness and blanking.
- Write handshake:
  - A transfer occurs when wr_valid && wr_ready. The data is latched into the shadow registers and pending is set; wr_ready is low while pending=1.
  - At a frame start with pending=1, shadow is copied to the active buffer, pending clears, and wr_ready returns high on the next cycle.
  - A transfer in the same cycle as a frame start is not applied at that frame start; it is applied at the following one.
- Hex decode (active-low, gfedcba):
  - 0 → 1000000, 1 → 1111001, 7 → 1111000, 8 → 0000000, A → 0001000, F → 0001110.
  - The remaining values use the standard hex font.
- Leading-zero blanking, when blank_lz=1:
  - Digit k∈{3,2,1} is blanked if its nibble and all higher nibbles are 0. Digit 0 is never blanked.
  - A blanked digit keeps its anode high for the whole slot; its dp is suppressed too.

## Timing
- All outputs are registered.
- Reset values: anode=4'hF, segment=7'h7F, dp=1, digit_idx=0, frame_done=0, wr_ready=1. Internal state: FSM=IDLE, active/shadow buffers=0, pending=0.
- Reset is asynchronous and takes effect immediately, including mid-DRIVE.
- Frame start to anode low: GUARD_CYC cycles after segment is updated, so segments never change while an anode is on.
- If refresh_clk_en falls, anode=4'hF on the next clock. Re-enable always restarts at digit 0 GUARD.
- With a continuously enabled scan, frame_done pulses once every 4*(GUARD_CYC+16*SUB_CYC) cycles.
- brightness changes mid-slot take effect at the next GUARD entry.

## Structure
- `seg_pkg` holds:
  - the state enum `scan_state_t`;
  - constants `SEG_BLANK=7'h7F` and `N_DIGITS=4`;
  - the hex-to-segment lookup function.
- Sub-module `seg_hex_decode` is the combinational nibble → segment decoder using the package function.
- One cycle counter, sized for max(GUARD_CYC, SUB_CYC). One 4-bit sub-slot counter.

## Test plan
Bench parameters: SUB_CYC=4, GUARD_CYC=2, so a slot is 66 cycles.
1. Reset and default display.
   - Stimulus: rstN low, then released, refresh_clk_en=1, no writes, blank_lz=0, brightness=15.
   - During reset: anode=F, segment=7F, wr_ready=1.
   - After release: digit 0 slot shows segment=1000000, with anode=1110 for 64 cycles after a 2-cycle guard.
2. Write and frame-boundary apply.
   - Stimulus: write 16'h12AF with wr_dp=4'b0100.
   - wr_ready stays 0 until the next frame start.
   - Next frame: digit 0=0001110, digit 1=0001000, digit 2=0100100 with dp=0, digit 3=1111001.
3. Brightness.
   - brightness=3 → anode low for 16 cycles, then 4'hF for 48 cycles per slot.
   - brightness=0 → anode low for 4 cycles.
4. Leading-zero blanking.
   - Stimulus: blank_lz=1, data 16'h0070.
   - Digits 3 and 2: anode=F for the whole slot.
   - Digit 1: 1111000. Digit 0: 1000000.
   - Slot length stays 66 cycles.
5. Enable drop.
   - refresh_clk_en→0 mid-DRIVE → anode=F on the next clock.
   - Re-enable → digit_idx=0 and a GUARD of 2 cycles.
   - Async reset asserted mid-DRIVE → immediate reset values.
6. Handshake corner.
   - A write accepted on the frame-start cycle is not displayed that frame; it is displayed at the following frame start.
   - wr_ready stays low throughout.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, constants and hex font for the seven-segment scan controller
package seg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUARD,
    S_DRIVE,
    S_OFF
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         N_DIGITS  = 4;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational nibble to active-low segment decoder
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed display scan with guard, PWM brightness,
// leading-zero blanking and frame-synchronous double-buffered data
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SUB_CYC   = 3125,
  parameter int GUARD_CYC = 16
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                refresh_clk_en,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [15:0]         wr_data,
  input  logic [N_DIGITS-1:0] wr_dp,
  input  logic [3:0]          brightness,
  input  logic                blank_lz,
  output logic [6:0]          segment,
  output logic                dp,
  output logic [N_DIGITS-1:0] anode,
  output logic [1:0]          digit_idx,
  output logic                frame_done
);

  localparam int MAX_CYC = (GUARD_CYC > SUB_CYC) ? GUARD_CYC : SUB_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] SUB_LAST   = CW'(SUB_CYC - 1);

  scan_state_t         state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [3:0]          sub, sub_n;
  logic [1:0]          digit_n;
  logic [3:0]          bri, bri_n;
  logic                blanked, blanked_n;
  logic                guard_entry, frame_start, slot_end;
  logic [15:0]         active, shadow, eff_data;
  logic [N_DIGITS-1:0] active_dp, shadow_dp, eff_dp, lz;
  logic                pending, pending_n, xfer, blank_now;
  logic [3:0]          nibble;
  logic [6:0]          seg_code, segment_d;
  logic                dp_d, frame_done_d;
  logic [N_DIGITS-1:0] anode_d;

  assign xfer = wr_valid && wr_ready;

  seg_hex_decode u_dec (
    .nibble (nibble),
    .seg    (seg_code)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sub        <= '0;
      digit_idx  <= '0;
      bri        <= '0;
      blanked    <= 1'b0;
      active     <= '0;
      active_dp  <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      wr_ready   <= 1'b1;
      anode      <= '1;
      segment    <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sub        <= sub_n;
      digit_idx  <= digit_n;
      bri        <= bri_n;
      blanked    <= blanked_n;
      if (frame_start && pending) begin
        active    <= shadow;
        active_dp <= shadow_dp;
      end
      if (xfer) begin
        shadow    <= wr_data;
        shadow_dp <= wr_dp;
      end
      pending    <= pending_n;
      wr_ready   <= ~pending_n;
      anode      <= anode_d;
      segment    <= segment_d;
      dp         <= dp_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sub_n       = sub;
    digit_n     = digit_idx;
    bri_n       = bri;
    guard_entry = 1'b0;
    frame_start = 1'b0;
    slot_end    = 1'b0;
    if (!refresh_clk_en) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      sub_n   = '0;
      digit_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n     = S_GUARD;
          cnt_n       = '0;
          digit_n     = '0;
          guard_entry = 1'b1;
          frame_start = 1'b1;
        end
        S_GUARD: begin
          if (cnt == GUARD_LAST) begin
            state_n = S_DRIVE;
            cnt_n   = '0;
            sub_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt == SUB_LAST) begin
            cnt_n = '0;
            if (sub != bri) begin
              sub_n = sub + 4'd1;
            end else if (bri == 4'hF) begin
              slot_end = 1'b1;
            end else begin
              state_n = S_OFF;
              sub_n   = sub + 4'd1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_OFF: begin
          if (cnt == SUB_LAST) begin
            cnt_n = '0;
            if (sub == 4'hF) slot_end = 1'b1;
            else             sub_n    = sub + 4'd1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
      if (slot_end) begin
        state_n     = S_GUARD;
        cnt_n       = '0;
        digit_n     = digit_idx + 2'd1;
        guard_entry = 1'b1;
        frame_start = (digit_idx == 2'd3);
      end
    end
    if (guard_entry) bri_n = brightness;
    // A write landing on the frame-start edge has pending=0 here, so it waits a frame
    pending_n = xfer || (pending && !frame_start);
  end

  always_comb begin
    eff_data  = (frame_start && pending) ? shadow    : active;
    eff_dp    = (frame_start && pending) ? shadow_dp : active_dp;
    nibble    = eff_data[{digit_n, 2'b00} +: 4];
    lz[3]     = (eff_data[15:12] == 4'h0);
    lz[2]     = lz[3] && (eff_data[11:8] == 4'h0);
    lz[1]     = lz[2] && (eff_data[7:4] == 4'h0);
    lz[0]     = 1'b0;
    blank_now = blank_lz && lz[digit_n];
    segment_d = segment;
    dp_d      = dp;
    blanked_n = blanked;
    if (state_n == S_IDLE) begin
      segment_d = SEG_BLANK;
      dp_d      = 1'b1;
      blanked_n = 1'b0;
    end else if (guard_entry) begin
      blanked_n = blank_now;
      segment_d = blank_now ? SEG_BLANK : seg_code;
      dp_d      = blank_now || !eff_dp[digit_n];
    end
    anode_d = '1;
    if (state_n == S_DRIVE && !blanked_n) anode_d = ~(4'b0001 << digit_n);
    frame_done_d = (digit_n == 2'd3) && (cnt_n == SUB_LAST) && (sub_n == 4'hF) &&
                   ((state_n == S_OFF) || (state_n == S_DRIVE && bri_n == 4'hF));
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        refresh_clk_en;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  brightness;
  logic        blank_lz;
  logic [6:0]  segment;
  logic        dp;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SUB_CYC(4), .GUARD_CYC(2)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .refresh_clk_en (refresh_clk_en),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .wr_dp          (wr_dp),
    .brightness     (brightness),
    .blank_lz       (blank_lz),
    .segment        (segment),
    .dp             (dp),
    .anode          (anode),
    .digit_idx      (digit_idx),
    .frame_done     (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench on the first cycle of digit-0 GUARD of the next frame
  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 400), 32'd1);
    tick();
  endtask

  // Called on the first cycle of a slot; observes 66 cycles and moves to the next slot start
  task automatic check_slot(input string tag, input logic [1:0] d, input logic [6:0] exp_seg,
                            input logic exp_dp, input int exp_low, input logic [3:0] exp_pat);
    logic [6:0] seg_v;
    logic       dp_v;
    logic [3:0] pat;
    int         low, first;
    logic       len_ok;
    seg_v  = segment;
    dp_v   = dp;
    pat    = 4'hF;
    low    = 0;
    first  = -1;
    len_ok = 1'b1;
    chk({tag, "_digit"}, 32'(digit_idx), 32'(d));
    for (int i = 0; i < 66; i++) begin
      if (digit_idx !== d) len_ok = 1'b0;
      if (anode !== 4'hF) begin
        if (first < 0) first = i;
        low++;
        pat = anode;
      end
      if (i < 65) tick();
    end
    tick();
    if (digit_idx !== d + 2'd1) len_ok = 1'b0;
    if (exp_low > 0) chk({tag, "_seg"}, 32'(seg_v), 32'(exp_seg));
    chk({tag, "_dp"}, 32'(dp_v), 32'(exp_dp));
    chk({tag, "_low"}, 32'(low), 32'(exp_low));
    chk({tag, "_first"}, 32'(first), (exp_low > 0) ? 32'd2 : 32'hFFFF_FFFF);
    chk({tag, "_pat"}, 32'(pat), 32'(exp_pat));
    chk({tag, "_len"}, 32'(len_ok), 32'd1);
  endtask

  initial begin
    int  n;
    logic low_all;
    rstN = 1'b0;
    refresh_clk_en = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    wr_dp = '0;
    brightness = 4'd15;
    blank_lz = 1'b0;

    // 1: reset values, then default display of zeros
    repeat (3) tick();
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(segment), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_digit", 32'(digit_idx), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    refresh_clk_en = 1'b1;
    rstN = 1'b1;
    tick();
    check_slot("t1_d0", 2'd0, 7'b1000000, 1'b1, 64, 4'hE);

    // 2: write is held in shadow until the next frame start
    wr_valid = 1'b1;
    wr_data  = 16'h12AF;
    wr_dp    = 4'b0100;
    tick();
    wr_valid = 1'b0;
    chk("t2_ready_low", 32'(wr_ready), 32'd0);
    n = 0;
    low_all = 1'b1;
    while (frame_done !== 1'b1 && n < 400) begin
      if (wr_ready !== 1'b0) low_all = 1'b0;
      tick();
      n++;
    end
    chk("t2_sync", 32'(n < 400), 32'd1);
    chk("t2_ready_held", 32'(low_all), 32'd1);
    tick();
    chk("t2_ready_back", 32'(wr_ready), 32'd1);
    check_slot("t2_d0", 2'd0, 7'b0001110, 1'b1, 64, 4'hE);
    check_slot("t2_d1", 2'd1, 7'b0001000, 1'b1, 64, 4'hD);
    check_slot("t2_d2", 2'd2, 7'b0100100, 1'b0, 64, 4'hB);
    check_slot("t2_d3", 2'd3, 7'b1111001, 1'b1, 64, 4'h7);

    // 3: brightness, sampled only at GUARD entry
    brightness = 4'd3;
    wait_frame("t3_sync");
    check_slot("t3_b3", 2'd0, 7'b0001110, 1'b1, 16, 4'hE);
    brightness = 4'd0;
    check_slot("t3_held", 2'd1, 7'b0001000, 1'b1, 16, 4'hD);
    check_slot("t3_b0", 2'd2, 7'b0100100, 1'b0, 4, 4'hB);

    // 4: leading-zero blanking on 0070
    brightness = 4'd15;
    blank_lz = 1'b1;
    chk("t4_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_data  = 16'h0070;
    wr_dp    = 4'b1100;
    tick();
    wr_valid = 1'b0;
    wait_frame("t4_sync");
    check_slot("t4_d0", 2'd0, 7'b1000000, 1'b1, 64, 4'hE);
    check_slot("t4_d1", 2'd1, 7'b1111000, 1'b1, 64, 4'hD);
    check_slot("t4_d2", 2'd2, 7'h7F, 1'b1, 0, 4'hF);
    check_slot("t4_d3", 2'd3, 7'h7F, 1'b1, 0, 4'hF);

    // 5: enable drop mid-DRIVE, restart, then asynchronous reset mid-DRIVE
    repeat (71) tick();
    chk("t5_drive_anode", 32'(anode), 32'hD);
    chk("t5_drive_digit", 32'(digit_idx), 32'd1);
    refresh_clk_en = 1'b0;
    tick();
    chk("t5_off_anode", 32'(anode), 32'hF);
    chk("t5_off_digit", 32'(digit_idx), 32'd0);
    tick();
    refresh_clk_en = 1'b1;
    tick();
    chk("t5_re_digit", 32'(digit_idx), 32'd0);
    chk("t5_re_guard0", 32'(anode), 32'hF);
    tick();
    chk("t5_re_guard1", 32'(anode), 32'hF);
    tick();
    chk("t5_re_drive", 32'(anode), 32'hE);
    repeat (3) tick();
    chk("t5_pre_rst", 32'(anode), 32'hE);
    #2;
    rstN = 1'b0;
    #1;
    chk("t5_rst_anode", 32'(anode), 32'hF);
    chk("t5_rst_seg", 32'(segment), 32'h7F);
    chk("t5_rst_digit", 32'(digit_idx), 32'd0);
    chk("t5_rst_ready", 32'(wr_ready), 32'd1);
    repeat (2) tick();
    rstN = 1'b1;

    // 6: write accepted on the frame-start edge is deferred a whole frame
    n = 0;
    while (frame_done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("t6_sync", 32'(n < 400), 32'd1);
    chk("t6_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_data  = 16'h3456;
    wr_dp    = 4'b0000;
    tick();
    wr_valid = 1'b0;
    chk("t6_digit", 32'(digit_idx), 32'd0);
    chk("t6_old_seg", 32'(segment), 32'h40);
    chk("t6_ready_low", 32'(wr_ready), 32'd0);
    n = 0;
    low_all = 1'b1;
    while (frame_done !== 1'b1 && n < 400) begin
      if (wr_ready !== 1'b0) low_all = 1'b0;
      tick();
      n++;
    end
    chk("t6_sync2", 32'(n < 400), 32'd1);
    chk("t6_ready_held", 32'(low_all), 32'd1);
    tick();
    chk("t6_new_seg", 32'(segment), 32'h02);
    chk("t6_ready_back", 32'(wr_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
